// File: rtl/debug_uart_wb_bridge.sv
// debug_uart_wb_bridge: UART-to-Wishbone debug master (8N1 RX commands in, Wishbone cycles out, read data back on TX)
// Ports:
//   core_clk, core_rst            clock, synchronous active-high reset
//   debug_in / debug_out          UART RX (async, idle high) / UART TX (idle high)
//   wb_cyc_o wb_stb_o wb_we_o     Wishbone master controls
//   wb_sel_o wb_adr_o wb_dat_o    byte selects, word address, write data
//   wb_dat_i wb_ack_i             read data, acknowledge
//   busy_o                        high whenever a frame is in progress
// Optional: define DEBUG_BRIDGE_TIMEOUT_EN to add an ack watchdog of TIMEOUT_CYCLES cycles.
module debug_uart_wb_bridge #(
    parameter int CLK_DIV        = 347,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        core_clk,
    input  logic        core_rst,
    input  logic        debug_in,
    output logic        debug_out,
    output logic        wb_cyc_o,
    output logic        wb_stb_o,
    output logic        wb_we_o,
    output logic [3:0]  wb_sel_o,
    output logic [29:0] wb_adr_o,
    output logic [31:0] wb_dat_o,
    input  logic [31:0] wb_dat_i,
    input  logic        wb_ack_i,
    output logic        busy_o
);
    localparam int CW = $clog2(CLK_DIV);
    localparam logic [CW-1:0] C_HALF = CW'(CLK_DIV / 2);
    localparam logic [CW-1:0] C_LAST = CW'(CLK_DIV - 1);

    typedef enum logic [2:0] {S_IDLE, S_LEN, S_ADDR, S_WDATA, S_WB, S_TX} state_t;
    state_t r_state, w_next;

    logic          r_rx_s1, r_rx_s2, r_rx_prev, r_rx_busy, r_rx_valid;
    logic [CW-1:0] r_rx_cnt;
    logic [3:0]    r_rx_bit;
    logic [7:0]    r_rx_sh;

    logic [9:0]    r_tx_sh;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]    r_tx_bit;
    logic          r_tx_busy;
    logic          w_tx_done, w_tx_start;
    logic [7:0]    w_tx_byte;

    logic [1:0]    r_idx;
    logic [7:0]    r_len;
    logic          r_we;
    logic [29:0]   r_adr;
    logic [31:0]   r_dat;
    logic          w_to, w_done;
    logic [31:0]   w_rd;

    // RX: bit 0 is the start bit, 1..8 data, 9 stop; the engine frees itself at mid-stop
    always_ff @(posedge core_clk) begin
        r_rx_s1    <= debug_in;
        r_rx_s2    <= r_rx_s1;
        r_rx_prev  <= r_rx_s2;
        r_rx_valid <= 1'b0;
        if (core_rst) begin
            r_rx_s1   <= 1'b1;
            r_rx_s2   <= 1'b1;
            r_rx_prev <= 1'b1;
            r_rx_busy <= 1'b0;
            r_rx_cnt  <= '0;
            r_rx_bit  <= '0;
            r_rx_sh   <= '0;
        end else if (!r_rx_busy) begin
            if (r_rx_prev && !r_rx_s2) begin
                r_rx_busy <= 1'b1;
                r_rx_cnt  <= '0;
                r_rx_bit  <= '0;
            end
        end else if (r_rx_cnt == C_HALF && r_rx_bit == 4'd9) begin
            r_rx_busy  <= 1'b0;
            r_rx_valid <= r_rx_s2;
        end else if (r_rx_cnt == C_HALF) begin
            if (r_rx_bit != 4'd0) r_rx_sh <= {r_rx_s2, r_rx_sh[7:1]};
            r_rx_cnt <= r_rx_cnt + 1'b1;
        end else if (r_rx_cnt == C_LAST) begin
            r_rx_cnt <= '0;
            r_rx_bit <= r_rx_bit + 1'b1;
        end else begin
            r_rx_cnt <= r_rx_cnt + 1'b1;
        end
    end

    // TX: shift register fills with ones, so the idle line is its LSB
    assign w_tx_done = r_tx_busy && r_tx_cnt == C_LAST && r_tx_bit == 4'd9;
    assign debug_out = r_tx_sh[0];

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_tx_sh   <= '1;
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_busy <= 1'b0;
        end else if (w_tx_start) begin
            r_tx_sh   <= {1'b1, w_tx_byte, 1'b0};
            r_tx_cnt  <= '0;
            r_tx_bit  <= '0;
            r_tx_busy <= 1'b1;
        end else if (r_tx_busy) begin
            if (r_tx_cnt == C_LAST) begin
                r_tx_cnt  <= '0;
                r_tx_sh   <= {1'b1, r_tx_sh[9:1]};
                r_tx_bit  <= r_tx_bit + 1'b1;
                r_tx_busy <= r_tx_bit != 4'd9;
            end else begin
                r_tx_cnt <= r_tx_cnt + 1'b1;
            end
        end
    end

`ifdef DEBUG_BRIDGE_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_to;
    always_ff @(posedge core_clk) begin
        if (core_rst || r_state != S_WB) r_to <= '0;
        else r_to <= r_to + 1'b1;
    end
    assign w_to = r_to == TW'(TIMEOUT_CYCLES - 1);
`else
    logic w_unused_to;
    assign w_unused_to = |TIMEOUT_CYCLES;
    assign w_to = 1'b0;
`endif

    assign w_done = wb_ack_i || w_to;
    assign w_rd   = wb_ack_i ? wb_dat_i : 32'hFFFF_FFFF;

    // The first read byte goes straight from the bus; later ones come from the upper-middle of r_dat before it shifts
    assign w_tx_start = (r_state == S_WB && !r_we && w_done) || (r_state == S_TX && w_tx_done && r_idx != 2'd3);
    assign w_tx_byte  = r_state == S_WB ? w_rd[31:24] : r_dat[23:16];

    always_ff @(posedge core_clk) begin
        if (core_rst) r_state <= S_IDLE;
        else r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (r_rx_valid && (r_rx_sh == 8'h01 || r_rx_sh == 8'h02)) w_next = S_LEN;
            S_LEN:   if (r_rx_valid) w_next = S_ADDR;
            S_ADDR:  if (r_rx_valid && r_idx == 2'd3) w_next = r_len == 8'd0 ? S_IDLE : r_we ? S_WDATA : S_WB;
            S_WDATA: if (r_rx_valid && r_idx == 2'd3) w_next = S_WB;
            S_WB:    if (w_done) w_next = !r_we ? S_TX : r_len == 8'd1 ? S_IDLE : S_WDATA;
            S_TX:    if (w_tx_done && r_idx == 2'd3) w_next = r_len == 8'd1 ? S_IDLE : S_WB;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge core_clk) begin
        if (core_rst) begin
            r_idx <= '0;
            r_len <= '0;
            r_we  <= 1'b0;
            r_adr <= '0;
            r_dat <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    r_idx <= '0;
                    if (w_next == S_LEN) r_we <= r_rx_sh == 8'h01;
                end
                S_LEN: if (r_rx_valid) r_len <= r_rx_sh;
                S_ADDR: if (r_rx_valid) begin
                    r_adr <= {r_adr[21:0], r_rx_sh};
                    r_idx <= r_idx + 1'b1;
                end
                S_WDATA: if (r_rx_valid) begin
                    r_dat <= {r_dat[23:0], r_rx_sh};
                    r_idx <= r_idx + 1'b1;
                end
                S_WB: if (w_done) begin
                    r_idx <= '0;
                    if (r_we) begin
                        r_adr <= r_adr + 1'b1;
                        r_len <= r_len - 1'b1;
                    end else begin
                        r_dat <= w_rd;
                    end
                end
                S_TX: if (w_tx_done) begin
                    r_dat <= {r_dat[23:0], 8'h00};
                    r_idx <= r_idx + 1'b1;
                    if (r_idx == 2'd3) begin
                        r_adr <= r_adr + 1'b1;
                        r_len <= r_len - 1'b1;
                    end
                end
                default: r_idx <= '0;
            endcase
        end
    end

    assign wb_cyc_o = r_state == S_WB;
    assign wb_stb_o = wb_cyc_o;
    assign wb_we_o  = wb_cyc_o && r_we;
    assign wb_sel_o = {4{wb_cyc_o}};
    assign wb_adr_o = r_adr;
    assign wb_dat_o = r_dat;
    assign busy_o   = r_state != S_IDLE;
endmodule

// File: tb/tb_debug_uart_wb_bridge.sv
// tb_debug_uart_wb_bridge: directed self-checking bench for the UART-to-Wishbone debug bridge
module tb_debug_uart_wb_bridge;
    logic        core_clk = 1'b0;
    logic        core_rst = 1'b1;
    logic        debug_in = 1'b1;
    logic        debug_out;
    logic        wb_cyc_o, wb_stb_o, wb_we_o;
    logic [3:0]  wb_sel_o;
    logic [29:0] wb_adr_o;
    logic [31:0] wb_dat_o;
    logic [31:0] wb_dat_i = '0;
    logic        wb_ack_i = 1'b0;
    logic        busy_o;

    int errors = 0;
    int checks = 0;

    logic [29:0] log_adr[$];
    logic        log_we[$];
    logic [31:0] log_dat[$];
    logic [3:0]  log_sel[$];
    logic [31:0] rd_q[$];
    logic [7:0]  tx_q[$];
    int          ack_delay = 0;
    bit          slave_en = 1'b1;
    int          cyc_drop = 0;
    int          gap_err = 0;
    int          run = 0;
    int          last_run = 0;

    debug_uart_wb_bridge #(.CLK_DIV(16), .TIMEOUT_CYCLES(64)) dut (
        .core_clk(core_clk), .core_rst(core_rst), .debug_in(debug_in), .debug_out(debug_out),
        .wb_cyc_o(wb_cyc_o), .wb_stb_o(wb_stb_o), .wb_we_o(wb_we_o), .wb_sel_o(wb_sel_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .busy_o(busy_o)
    );

    always #5 core_clk = ~core_clk;

    task automatic tick(input int n);
        repeat (n) @(posedge core_clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop);
        debug_in = 1'b0;
        tick(16);
        for (int i = 0; i < 8; i++) begin
            debug_in = b[i];
            tick(16);
        end
        debug_in = stop;
        tick(16);
        debug_in = 1'b1;
    endtask

    task automatic send_frame(input logic [127:0] f, input int n);
        for (int i = 0; i < n; i++) send_byte(f[8*(n-1-i) +: 8], 1'b1);
    endtask

    task automatic wait_idle(input int lim, input string tag);
        int n = 0;
        while (busy_o && n < lim) begin
            tick(1);
            n++;
        end
        check(tag, 64'(busy_o), 64'd0);
    endtask

    task automatic get_tx(input int n, output logic [63:0] v);
        v = '0;
        for (int i = 0; i < n; i++) v = {v[55:0], tx_q.size() > 0 ? tx_q.pop_front() : 8'h00};
    endtask

    task automatic clear_log;
        log_adr.delete();
        log_we.delete();
        log_dat.delete();
        log_sel.delete();
    endtask

    // Wishbone slave: acks after ack_delay cycles, logs every cycle it serves
    initial forever begin
        tick(1);
        if (wb_cyc_o && wb_stb_o && slave_en) begin
            for (int i = 0; i < ack_delay; i++) begin
                tick(1);
                if (!wb_cyc_o) cyc_drop++;
            end
            log_adr.push_back(wb_adr_o);
            log_we.push_back(wb_we_o);
            log_dat.push_back(wb_dat_o);
            log_sel.push_back(wb_sel_o);
            wb_dat_i = rd_q.size() > 0 ? rd_q.pop_front() : 32'h0;
            wb_ack_i = 1'b1;
            tick(1);
            wb_ack_i = 1'b0;
            if (wb_cyc_o) gap_err++;
        end
    end

    // Length of the most recent continuous cyc-high run
    initial forever begin
        tick(1);
        if (wb_cyc_o) run++;
        else if (run != 0) begin
            last_run = run;
            run = 0;
        end
    end

    // UART receiver on debug_out
    initial begin
        #20;
        forever begin
            logic [7:0] b;
            @(negedge debug_out);
            tick(8);
            for (int i = 0; i < 8; i++) begin
                tick(16);
                b[i] = debug_out;
            end
            tick(16);
            tx_q.push_back(b);
        end
    end

    initial begin
        logic [63:0] v;
        int n;
        tick(5);
        check("rst_out", 64'(debug_out), 64'd1);
        check("rst_cyc", 64'(wb_cyc_o), 64'd0);
        check("rst_stb", 64'(wb_stb_o), 64'd0);
        check("rst_we", 64'(wb_we_o), 64'd0);
        check("rst_sel", 64'(wb_sel_o), 64'd0);
        check("rst_adr", 64'(wb_adr_o), 64'd0);
        check("rst_dat", 64'(wb_dat_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        core_rst = 1'b0;
        tick(5);

        send_byte(8'h01, 1'b1);
        check("wr_busy_cmd", 64'(busy_o), 64'd1);
        send_frame(128'({8'h01, 8'h00, 8'h00, 8'h00, 8'h10, 8'hDE, 8'hAD, 8'hBE, 8'hEF}), 9);
        wait_idle(500, "wr_idle");
        check("wr_n", 64'(log_adr.size()), 64'd1);
        check("wr_adr", 64'(log_adr[0]), 64'h10);
        check("wr_we", 64'(log_we[0]), 64'd1);
        check("wr_dat", 64'(log_dat[0]), 64'hDEADBEEF);
        check("wr_sel", 64'(log_sel[0]), 64'hF);
        check("wr_gap", 64'(gap_err), 64'd0);
        clear_log();

        rd_q.push_back(32'h11223344);
        rd_q.push_back(32'h55667788);
        send_frame(128'({8'h02, 8'h02, 8'h00, 8'h00, 8'h00, 8'h20}), 6);
        wait_idle(4000, "rd_idle");
        tick(20);
        check("rd_n", 64'(log_adr.size()), 64'd2);
        check("rd_adr0", 64'(log_adr[0]), 64'h20);
        check("rd_adr1", 64'(log_adr[1]), 64'h21);
        check("rd_we", 64'(log_we[0] | log_we[1]), 64'd0);
        check("rd_txn", 64'(tx_q.size()), 64'd8);
        get_tx(8, v);
        check("rd_tx", v, 64'h1122334455667788);
        check("rd_gap", 64'(gap_err), 64'd0);
        clear_log();

        send_byte(8'h7E, 1'b1);
        check("bad_cmd_busy", 64'(busy_o), 64'd0);
        send_byte(8'h01, 1'b0);
        tick(32);
        check("frame_err_busy", 64'(busy_o), 64'd0);
        send_frame(128'({8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h05}), 6);
        tick(10);
        check("len0_busy", 64'(busy_o), 64'd0);
        check("len0_nocyc", 64'(log_adr.size()), 64'd0);
        send_frame(128'({8'h01, 8'h01, 8'h00, 8'h00, 8'h00, 8'h30, 8'hCA, 8'hFE, 8'hF0, 8'h0D}), 10);
        wait_idle(500, "edge_wr_idle");
        check("edge_wr_n", 64'(log_adr.size()), 64'd1);
        check("edge_wr_adr", 64'(log_adr[0]), 64'h30);
        check("edge_wr_dat", 64'(log_dat[0]), 64'hCAFEF00D);
        clear_log();

        ack_delay = 5;
        send_frame(128'({8'h01, 8'h02, 8'h3F, 8'hFF, 8'hFF, 8'hFF,
                         8'h11, 8'h11, 8'h11, 8'h11, 8'h22, 8'h22, 8'h22, 8'h22}), 14);
        wait_idle(500, "wrap_idle");
        check("wrap_n", 64'(log_adr.size()), 64'd2);
        check("wrap_adr0", 64'(log_adr[0]), 64'h3FFFFFFF);
        check("wrap_adr1", 64'(log_adr[1]), 64'h0);
        check("wrap_dat0", 64'(log_dat[0]), 64'h11111111);
        check("wrap_dat1", 64'(log_dat[1]), 64'h22222222);
        check("wrap_hold", 64'(cyc_drop), 64'd0);
        check("wrap_run", 64'(last_run), 64'd6);
        ack_delay = 0;
        clear_log();

        rd_q.push_back(32'hA1B2C3D4);
        send_frame(128'({8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h40}), 6);
        n = 0;
        while (tx_q.size() < 1 && n < 3000) begin
            tick(1);
            n++;
        end
        check("rr_first", 64'(tx_q.size() >= 1), 64'd1);
        n = 0;
        while (debug_out && n < 40) begin
            tick(1);
            n++;
        end
        tick(4);
        check("rr_mid_start", 64'(debug_out), 64'd0);
        core_rst = 1'b1;
        tick(1);
        check("rr_out", 64'(debug_out), 64'd1);
        check("rr_cyc", 64'(wb_cyc_o), 64'd0);
        check("rr_busy", 64'(busy_o), 64'd0);
        core_rst = 1'b0;
        tick(300);
        tx_q.delete();
        rd_q.delete();
        clear_log();
        rd_q.push_back(32'h0BADF00D);
        send_frame(128'({8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h44}), 6);
        wait_idle(2000, "rr2_idle");
        tick(20);
        check("rr2_adr", 64'(log_adr[0]), 64'h44);
        check("rr2_txn", 64'(tx_q.size()), 64'd4);
        get_tx(4, v);
        check("rr2_tx", v, 64'h0BADF00D);
        clear_log();

        slave_en = 1'b0;
        send_frame(128'({8'h02, 8'h01, 8'h00, 8'h00, 8'h00, 8'h50}), 6);
`ifdef DEBUG_BRIDGE_TIMEOUT_EN
        wait_idle(2000, "to_idle");
        tick(20);
        check("to_run", 64'(last_run), 64'd64);
        check("to_txn", 64'(tx_q.size()), 64'd4);
        get_tx(4, v);
        check("to_tx", v, 64'hFFFFFFFF);
`else
        tick(300);
        check("to_cyc_held", 64'(wb_cyc_o), 64'd1);
        check("to_busy_held", 64'(busy_o), 64'd1);
        core_rst = 1'b1;
        tick(2);
        check("to_rst_cyc", 64'(wb_cyc_o), 64'd0);
        core_rst = 1'b0;
`endif
        check("to_noslave", 64'(log_adr.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
